branch_redirect_controller: RTL and testbench
=============================================

Name: branch_redirect_controller

Overview:
- Sequences the pipeline response to a resolved control transfer.
- Consumes the EX-stage taken/not-taken result and the computed target, and issues the PC redirect to the fetch PC mux.
- Drives flushes of the IF/ID and ID/EX pipeline registers for a programmable number of cycles.
- Defers the redirect while the pipeline is stalled by memory. Sits between the branch comparison logic and the PC/pipeline-register control.

Parameters:
- FLUSH_CYCLES, 1, extra flush-only cycles after the redirect cycle; legal range 0..7.
- ADDR_W, 32, width of PC/target.

Ports:
- CLK  input  1  system clock; all state updates on posedge.
- RESET  input  1  synchronous, active-high reset.
- EX_VALID  input  1  EX stage holds a real (non-bubble) instruction.
- BRANCH_TAKEN  input  1  taken result for the EX instruction (1 for JAL/JALR and for satisfied BEQ/BNE/BLT/BGE/BLTU/BGEU).
- BRANCH_TARGET  input  ADDR_W  target address computed in EX.
- MEM_BUSY  input  1  pipeline-wide stall; the PC and pipeline registers do not advance while high.
- PC_SEL  output  1  1 = PC mux selects PC_REDIRECT.
- PC_REDIRECT  output  ADDR_W  registered target address.
- FLUSH_IF_ID  output  1  clear the IF/ID register at the next advancing edge.
- FLUSH_ID_EX  output  1  clear the ID/EX register at the next advancing edge.
- BUSY  output  1  high in any state other than IDLE.

Behaviour:
- Reset:
  - On a RESET edge the state goes to IDLE; PC_SEL, FLUSH_IF_ID, FLUSH_ID_EX and BUSY are 0; PC_REDIRECT is 0; the flush counter is 0.
  - RESET in any state abandons the pending redirect.
- States: IDLE, PENDING, REDIRECT, FLUSH. All outputs are registered (decoded from the state register); no combinational path from inputs to outputs.
- Resolve event: EX_VALID=1 and BRANCH_TAKEN=1 sampled at a posedge while in IDLE. The edge latches BRANCH_TARGET into PC_REDIRECT.
- IDLE:
  - Resolve event with MEM_BUSY=0 -> REDIRECT.
  - Resolve event with MEM_BUSY=1 -> PENDING.
  - Otherwise stay in IDLE.
  - EX_VALID=0 or BRANCH_TAKEN=0 -> no action.
- PENDING:
  - Outputs: BUSY=1, PC_SEL=0, FLUSH_IF_ID=0, FLUSH_ID_EX=0.
  - Go to REDIRECT on the first edge with MEM_BUSY=0.
  - PC_REDIRECT is held.
- REDIRECT:
  - Outputs: PC_SEL=1, FLUSH_IF_ID=1, FLUSH_ID_EX=1, BUSY=1.
  - Held while MEM_BUSY=1.
  - On an edge with MEM_BUSY=0: if FLUSH_CYCLES=0 go to IDLE; else load the counter with FLUSH_CYCLES and go to FLUSH.
  - Redirect latency: the PC loads the target one cycle after the resolve edge when there is no stall.
- FLUSH:
  - Outputs: PC_SEL=0, FLUSH_IF_ID=1, FLUSH_ID_EX=1, BUSY=1.
  - The counter decrements only on edges with MEM_BUSY=0.
  - Go to IDLE on the edge where the counter goes 1->0.
- Wrong-path handling: resolve events while not IDLE come from wrong-path instructions and are ignored. They must not change the state or PC_REDIRECT.
- Same-edge exit and resolve: when the controller leaves FLUSH or REDIRECT for IDLE, a resolve event on that same edge is ignored; only events sampled while in IDLE count.
- Target width: PC_REDIRECT is passed through unmodified; no alignment masking.

Optional Feature:
- Macro: BRANCH_REDIRECT_STATS_EN.
- Defined:
  - Adds output REDIRECT_COUNT[31:0], reset to 0.
  - Increments by 1 on each REDIRECT->(FLUSH|IDLE) transition.
  - Wraps from 0xFFFFFFFF to 0.
  - Adds input STATS_CLR (1 bit), which synchronously zeroes the counter and has priority over the increment.
- Undefined: neither port exists and no counter logic is generated; all other behaviour is identical.

Test Plan:
- Reset: RESET=1 for 2 cycles, then release with no branch activity -> all outputs 0, BUSY=0, PC_REDIRECT=0x00000000.
- Taken branch, no stall (FLUSH_CYCLES=1): EX_VALID=1, BRANCH_TAKEN=1, BRANCH_TARGET=0x00000040, MEM_BUSY=0 at edge t.
  - Cycle t+1: PC_SEL=1, both flushes 1, PC_REDIRECT=0x40.
  - Cycle t+2: PC_SEL=0, flushes 1.
  - Cycle t+3: IDLE, all 0.
- Stalled resolve: taken branch to 0x00000100 with MEM_BUSY=1 held for 3 cycles.
  - BUSY=1 with PC_SEL=0 during the stall.
  - PC_SEL=1 starts the cycle after MEM_BUSY falls; PC_REDIRECT=0x100 throughout.
- Wrong-path suppression: a second taken resolve (target 0x00000200) arrives during REDIRECT/FLUSH -> PC_REDIRECT stays 0x40 and no second PC_SEL pulse.
- Not taken and bubble: EX_VALID=1, BRANCH_TAKEN=0; then EX_VALID=0, BRANCH_TAKEN=1 -> state stays IDLE, no outputs asserted.
- Reset mid-operation plus stats (BRANCH_REDIRECT_STATS_EN, FLUSH_CYCLES=3):
  - Three redirects -> REDIRECT_COUNT=3.
  - RESET during FLUSH -> IDLE next cycle, flushes 0, REDIRECT_COUNT=0.
  - STATS_CLR coincident with a redirect exit -> count 0.

Source files
------------

// File: rtl/branch_redirect_controller.sv
`default_nettype none
// ============================================================================
// Module      : branch_redirect_controller
// Description : Turns a resolved taken control transfer from EX into a PC
//               redirect plus IF/ID and ID/EX flushes. The flushes last for
//               the redirect cycle plus FLUSH_CYCLES extra cycles. While
//               MEM_BUSY stalls the pipeline, the redirect is deferred.
//               Optional feature macro: BRANCH_REDIRECT_STATS_EN adds a
//               redirect counter (REDIRECT_COUNT) with a clear (STATS_CLR).
// Revision    : 1.0 - initial release
// ============================================================================
module branch_redirect_controller #(
    parameter int FLUSH_CYCLES = 1,
    parameter int ADDR_W       = 32
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              EX_VALID,
    input  logic              BRANCH_TAKEN,
    input  logic [ADDR_W-1:0] BRANCH_TARGET,
    input  logic              MEM_BUSY,
`ifdef BRANCH_REDIRECT_STATS_EN
    input  logic              STATS_CLR,
    output logic [31:0]       REDIRECT_COUNT,
`endif
    output logic              PC_SEL,
    output logic [ADDR_W-1:0] PC_REDIRECT,
    output logic              FLUSH_IF_ID,
    output logic              FLUSH_ID_EX,
    output logic              BUSY
);

    // The counter is 3 bits wide, so the flush length is held to 0..7.
    localparam logic [2:0] C_FLUSH_LOAD = 3'(FLUSH_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_PENDING  = 2'd1,
        S_REDIRECT = 2'd2,
        S_FLUSH    = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [2:0]        r_flush_cnt;
    logic [2:0]        w_flush_cnt_nxt;
    logic [ADDR_W-1:0] r_target;
    logic [ADDR_W-1:0] w_target_nxt;
    logic              w_resolve;

    // A resolve is a real instruction in EX whose transfer is taken.
    assign w_resolve = EX_VALID & BRANCH_TAKEN;

    // State, flush counter and latched target registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state     <= S_IDLE;
            r_flush_cnt <= 3'd0;
            r_target    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_flush_cnt <= w_flush_cnt_nxt;
            r_target    <= w_target_nxt;
        end
    end

    // Next-state logic. Resolves are only accepted in IDLE. Any resolve seen
    // in another state comes from a wrong-path instruction, including one that
    // arrives on the edge where the controller returns to IDLE.
    always_comb begin
        w_state_nxt     = r_state;
        w_flush_cnt_nxt = r_flush_cnt;
        w_target_nxt    = r_target;
        case (r_state)
            S_IDLE: begin
                if (w_resolve) begin
                    w_target_nxt = BRANCH_TARGET;
                    w_state_nxt  = MEM_BUSY ? S_PENDING : S_REDIRECT;
                end
            end
            S_PENDING: begin
                if (!MEM_BUSY) begin
                    w_state_nxt = S_REDIRECT;
                end
            end
            S_REDIRECT: begin
                // Hold PC_SEL until the PC can actually advance and load it.
                if (!MEM_BUSY) begin
                    if (C_FLUSH_LOAD == 3'd0) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_flush_cnt_nxt = C_FLUSH_LOAD;
                        w_state_nxt     = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                // Only edges that advance the pipeline consume a flush cycle.
                if (!MEM_BUSY) begin
                    w_flush_cnt_nxt = r_flush_cnt - 3'd1;
                    if (r_flush_cnt == 3'd1) begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt     = S_IDLE;
                w_flush_cnt_nxt = 3'd0;
            end
        endcase
    end

    // Outputs are decoded only from registers, so no input reaches an output
    // combinationally.
    always_comb begin
        PC_SEL      = (r_state == S_REDIRECT);
        FLUSH_IF_ID = (r_state == S_REDIRECT) || (r_state == S_FLUSH);
        FLUSH_ID_EX = (r_state == S_REDIRECT) || (r_state == S_FLUSH);
        BUSY        = (r_state != S_IDLE);
        PC_REDIRECT = r_target;
    end

`ifdef BRANCH_REDIRECT_STATS_EN
    logic [31:0] r_redirect_count;
    logic        w_redirect_exit;

    // One count per redirect that completes, that is, once the PC has loaded.
    assign w_redirect_exit = (r_state == S_REDIRECT) && !MEM_BUSY;

    // Redirect statistics counter. A clear wins over an increment on the same edge.
    always_ff @(posedge CLK) begin
        if (RESET || STATS_CLR) begin
            r_redirect_count <= 32'd0;
        end else if (w_redirect_exit) begin
            r_redirect_count <= r_redirect_count + 32'd1;
        end
    end

    assign REDIRECT_COUNT = r_redirect_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_redirect_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_redirect_controller
// Description : Self-checking bench for branch_redirect_controller. Two DUT
//               instances (FLUSH_CYCLES = 1 and 3) share the same stimulus.
//               Each is compared against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_redirect_controller;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        EX_VALID = 1'b0;
    logic        BRANCH_TAKEN = 1'b0;
    logic [31:0] BRANCH_TARGET = 32'd0;
    logic        MEM_BUSY = 1'b0;
    logic        STATS_CLR = 1'b0;

    logic        pc_sel0, fif0, fex0, busy0;
    logic        pc_sel1, fif1, fex1, busy1;
    logic [31:0] redir0, redir1;
    logic [31:0] cnt0, cnt1;

    wire  [35:0] d0 = {pc_sel0, fif0, fex0, busy0, redir0};
    wire  [35:0] d1 = {pc_sel1, fif1, fex1, busy1, redir1};

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 CLK = ~CLK;

    branch_redirect_controller #(.FLUSH_CYCLES(1), .ADDR_W(32)) u_dut0 (
        .CLK(CLK), .RESET(RESET), .EX_VALID(EX_VALID), .BRANCH_TAKEN(BRANCH_TAKEN),
        .BRANCH_TARGET(BRANCH_TARGET), .MEM_BUSY(MEM_BUSY),
`ifdef BRANCH_REDIRECT_STATS_EN
        .STATS_CLR(STATS_CLR), .REDIRECT_COUNT(cnt0),
`endif
        .PC_SEL(pc_sel0), .PC_REDIRECT(redir0), .FLUSH_IF_ID(fif0),
        .FLUSH_ID_EX(fex0), .BUSY(busy0)
    );

    branch_redirect_controller #(.FLUSH_CYCLES(3), .ADDR_W(32)) u_dut1 (
        .CLK(CLK), .RESET(RESET), .EX_VALID(EX_VALID), .BRANCH_TAKEN(BRANCH_TAKEN),
        .BRANCH_TARGET(BRANCH_TARGET), .MEM_BUSY(MEM_BUSY),
`ifdef BRANCH_REDIRECT_STATS_EN
        .STATS_CLR(STATS_CLR), .REDIRECT_COUNT(cnt1),
`endif
        .PC_SEL(pc_sel1), .PC_REDIRECT(redir1), .FLUSH_IF_ID(fif1),
        .FLUSH_ID_EX(fex1), .BUSY(busy1)
    );

`ifndef BRANCH_REDIRECT_STATS_EN
    assign cnt0 = 32'd0;
    assign cnt1 = 32'd0;
`endif

    // Behavioural model: a redirect is "waiting" for the stall to clear, then
    // "issuing" (PC_SEL) until an advancing edge, then owes a number of
    // flush-only advancing cycles.
    int          m_wait  [2];
    int          m_issue [2];
    int          m_owed  [2];
    logic [31:0] m_tgt   [2];
    logic [31:0] m_cnt   [2];
    int          fc      [2] = '{1, 3};

    function automatic logic [35:0] exp_vec(input int i);
        logic active;
        logic flush;
        active = (m_wait[i] != 0) || (m_issue[i] != 0) || (m_owed[i] > 0);
        flush  = (m_issue[i] != 0) || (m_owed[i] > 0);
        return {m_issue[i] != 0, flush, flush, active, m_tgt[i]};
    endfunction

    // One clock edge: the model consumes the same inputs the DUTs sample.
    task automatic step();
        @(posedge CLK);
        for (int i = 0; i < 2; i++) begin
            if (RESET) begin
                m_wait[i] = 0; m_issue[i] = 0; m_owed[i] = 0;
                m_tgt[i] = 32'd0; m_cnt[i] = 32'd0;
            end else begin
                logic exiting;
                exiting = (m_issue[i] != 0) && !MEM_BUSY;
                if (m_wait[i] == 0 && m_issue[i] == 0 && m_owed[i] == 0) begin
                    if (EX_VALID && BRANCH_TAKEN) begin
                        m_tgt[i] = BRANCH_TARGET;
                        if (MEM_BUSY) m_wait[i] = 1;
                        else          m_issue[i] = 1;
                    end
                end else if (m_wait[i] != 0) begin
                    if (!MEM_BUSY) begin m_wait[i] = 0; m_issue[i] = 1; end
                end else if (m_issue[i] != 0) begin
                    if (!MEM_BUSY) begin m_issue[i] = 0; m_owed[i] = fc[i]; end
                end else begin
                    if (!MEM_BUSY) m_owed[i] = m_owed[i] - 1;
                end
                if (STATS_CLR)    m_cnt[i] = 32'd0;
                else if (exiting) m_cnt[i] = m_cnt[i] + 32'd1;
            end
        end
        #1;
    endtask

    task automatic drive(input logic v, input logic t, input logic [31:0] a, input logic mb);
        EX_VALID = v; BRANCH_TAKEN = t; BRANCH_TARGET = a; MEM_BUSY = mb;
    endtask

    task automatic drain();
        drive(1'b0, 1'b0, 32'd0, 1'b0);
        STATS_CLR = 1'b0;
        for (int k = 0; k < 6; k++) step();
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        drive(1'b0, 1'b0, 32'd0, 1'b0);
        step(); step();
        RESET = 1'b0;
        step();
        n_cmp++;
        if (d0 !== 36'h0) begin n_fail++; $display("FAIL reset_dut0 got %h want %h", d0, 36'h0); end
        n_cmp++;
        if (d1 !== 36'h0) begin n_fail++; $display("FAIL reset_dut1 got %h want %h", d1, 36'h0); end
`ifdef BRANCH_REDIRECT_STATS_EN
        n_cmp++;
        if (cnt0 !== 32'd0) begin n_fail++; $display("FAIL reset_count got %h want 0", cnt0); end
`endif
    endtask

    task automatic test_taken_no_stall();
        drive(1'b1, 1'b1, 32'h40, 1'b0);
        step();
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        n_cmp++;
        if (d0 !== {4'b1111, 32'h40}) begin n_fail++; $display("FAIL taken_t1 got %h want %h", d0, {4'b1111, 32'h40}); end
        step();
        n_cmp++;
        if (d0 !== {4'b0111, 32'h40}) begin n_fail++; $display("FAIL taken_t2 got %h want %h", d0, {4'b0111, 32'h40}); end
        step();
        n_cmp++;
        if (d0 !== {4'b0000, 32'h40}) begin n_fail++; $display("FAIL taken_t3 got %h want %h", d0, {4'b0000, 32'h40}); end
        // The FLUSH_CYCLES=3 instance keeps flushing through three extra cycles.
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (d1 !== exp_vec(1)) begin n_fail++; $display("FAIL taken_fc3 cyc%0d got %h want %h", k, d1, exp_vec(1)); end
            step();
        end
        n_cmp++;
        if (d1 !== {4'b0000, 32'h40}) begin n_fail++; $display("FAIL taken_fc3_idle got %h want %h", d1, {4'b0000, 32'h40}); end
        drain();
    endtask

    task automatic test_stalled();
        drive(1'b1, 1'b1, 32'h100, 1'b1);
        step();
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (d0 !== {4'b0001, 32'h100}) begin n_fail++; $display("FAIL stall_hold cyc%0d got %h want %h", k, d0, {4'b0001, 32'h100}); end
            if (k < 2) step();
        end
        MEM_BUSY = 1'b0;
        step();
        n_cmp++;
        if (d0 !== {4'b1111, 32'h100}) begin n_fail++; $display("FAIL stall_release got %h want %h", d0, {4'b1111, 32'h100}); end
        n_cmp++;
        if (d1 !== exp_vec(1)) begin n_fail++; $display("FAIL stall_release_fc3 got %h want %h", d1, exp_vec(1)); end
        drain();
    endtask

    task automatic test_wrong_path();
        int pulses;
        pulses = 0;
        drive(1'b1, 1'b1, 32'h40, 1'b0);
        step();
        if (pc_sel0) pulses++;
        // Wrong-path resolves during REDIRECT, FLUSH and on the exit edge.
        drive(1'b1, 1'b1, 32'h200, 1'b0);
        for (int k = 0; k < 2; k++) begin
            step();
            if (pc_sel0) pulses++;
            n_cmp++;
            if (redir0 !== 32'h40) begin n_fail++; $display("FAIL wrong_path_target cyc%0d got %h want %h", k, redir0, 32'h40); end
        end
        n_cmp++;
        if (d0 !== {4'b0000, 32'h40}) begin n_fail++; $display("FAIL wrong_path_exit got %h want %h", d0, {4'b0000, 32'h40}); end
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        step();
        if (pc_sel0) pulses++;
        n_cmp++;
        if (pulses !== 1) begin n_fail++; $display("FAIL wrong_path_pulses got %0d want 1", pulses); end
        drain();
    endtask

    task automatic test_not_taken();
        logic [31:0] prev;
        prev = redir0;
        drive(1'b1, 1'b0, 32'h300, 1'b0);
        step();
        n_cmp++;
        if (d0 !== {4'b0000, prev}) begin n_fail++; $display("FAIL not_taken got %h want %h", d0, {4'b0000, prev}); end
        drive(1'b0, 1'b1, 32'h304, 1'b0);
        step();
        n_cmp++;
        if (d0 !== {4'b0000, prev}) begin n_fail++; $display("FAIL bubble got %h want %h", d0, {4'b0000, prev}); end
        n_cmp++;
        if (d1 !== exp_vec(1)) begin n_fail++; $display("FAIL bubble_fc3 got %h want %h", d1, exp_vec(1)); end
        drain();
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 1'b1, 32'h500, 1'b0);
        step();
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        step();
        n_cmp++;
        if (d1 !== {4'b0111, 32'h500}) begin n_fail++; $display("FAIL reset_mid_flush got %h want %h", d1, {4'b0111, 32'h500}); end
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        n_cmp++;
        if (d1 !== 36'h0) begin n_fail++; $display("FAIL reset_mid_cleared got %h want %h", d1, 36'h0); end
`ifdef BRANCH_REDIRECT_STATS_EN
        n_cmp++;
        if (cnt1 !== 32'd0) begin n_fail++; $display("FAIL reset_mid_count got %h want 0", cnt1); end
`endif
        drain();
    endtask

`ifdef BRANCH_REDIRECT_STATS_EN
    task automatic test_stats();
        RESET = 1'b1; step(); RESET = 1'b0;
        for (int r = 0; r < 3; r++) begin
            drive(1'b1, 1'b1, 32'h1000 + 32'(r * 4), 1'b0);
            step();
            drain();
        end
        n_cmp++;
        if (cnt1 !== 32'd3) begin n_fail++; $display("FAIL stats_three got %0d want 3", cnt1); end
        n_cmp++;
        if (cnt0 !== 32'd3) begin n_fail++; $display("FAIL stats_three_fc1 got %0d want 3", cnt0); end
        drive(1'b1, 1'b1, 32'h2000, 1'b0);
        step();
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        STATS_CLR = 1'b1;
        step();
        STATS_CLR = 1'b0;
        n_cmp++;
        if (cnt1 !== 32'd0) begin n_fail++; $display("FAIL stats_clr_exit got %0d want 0", cnt1); end
        drain();
    endtask
`endif

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            RESET = ($urandom_range(0, 59) == 0);
            STATS_CLR = ($urandom_range(0, 24) == 0);
            drive($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
                  $urandom, $urandom_range(0, 9) < 3);
            step();
            n_cmp++;
            if (d0 !== exp_vec(0)) begin n_fail++; $display("FAIL random_dut0 cyc%0d got %h want %h", k, d0, exp_vec(0)); end
            n_cmp++;
            if (d1 !== exp_vec(1)) begin n_fail++; $display("FAIL random_dut1 cyc%0d got %h want %h", k, d1, exp_vec(1)); end
`ifdef BRANCH_REDIRECT_STATS_EN
            n_cmp++;
            if (cnt1 !== m_cnt[1]) begin n_fail++; $display("FAIL random_count cyc%0d got %0d want %0d", k, cnt1, m_cnt[1]); end
`endif
        end
        RESET = 1'b0;
        drain();
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_wait[i] = 0; m_issue[i] = 0; m_owed[i] = 0;
            m_tgt[i] = 32'd0; m_cnt[i] = 32'd0;
        end
        test_reset();
        test_taken_no_stall();
        test_stalled();
        test_wrong_path();
        test_not_taken();
        test_reset_mid();
`ifdef BRANCH_REDIRECT_STATS_EN
        test_stats();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
